// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state;
    logic [5:0]         cnt;
    logic [WIDTH-1:0]   mag_a;      // multiplicand magnitude
    logic [WIDTH-1:0]   mag_b;      // multiplier / divisor magnitude
    logic [WIDTH-1:0]   raw_a;      // dividend as issued, returned in HI on divide by zero
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;        // holds the dividend magnitude, shifted out as quotient bits come in
    logic [2*WIDTH-1:0] acc;        // product accumulator; low half starts as the multiplier
    logic               neg_res;    // negate product / quotient
    logic               neg_rem;    // negate remainder
    logic               is_div;
    logic               div_zero;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes, one shift-add / restoring-divide step, and final sign fix-up.
    // A magnitude of 2^31 is representable as an unsigned WIDTH-bit value, so no extra bit is needed.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & rs_val[WIDTH-1];
        b_neg     = signed_op & rt_val[WIDTH-1];
        a_mag     = a_neg ? ({WIDTH{1'b0}} - rs_val) : rs_val;
        b_mag     = b_neg ? ({WIDTH{1'b0}} - rt_val) : rt_val;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        div_trial = {rem, quo[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, mag_b};
        div_diff  = div_trial[WIDTH-1:0] - mag_b;
        prod_fix  = neg_res ? ({(2*WIDTH){1'b0}} - acc) : acc;
        quo_fix   = neg_res ? ({WIDTH{1'b0}} - quo) : quo;
        rem_fix   = neg_rem ? ({WIDTH{1'b0}} - rem) : rem;
    end

    // Control FSM and datapath; HI/LO change only on MTHI/MTLO or in FIX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            mag_a    <= '0;
            mag_b    <= '0;
            raw_a    <= '0;
            rem      <= '0;
            quo      <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                mag_a    <= a_mag;
                                mag_b    <= b_mag;
                                raw_a    <= rs_val;
                                acc      <= {{WIDTH{1'b0}}, b_mag};
                                rem      <= '0;
                                quo      <= a_mag;
                                neg_res  <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                                is_div   <= op[1];
                                div_zero <= (rt_val == '0);
                                cnt      <= 6'd0;
                                busy     <= 1'b1;
                                state    <= op[1] ? S_DIV : S_MUL;
                            end
                            OP_MTHI: begin
                                hi   <= rs_val;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= rs_val;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= S_FIX;
                end
                S_DIV: begin
                    quo <= {quo[WIDTH-2:0], div_ge};
                    rem <= div_ge ? div_diff : div_trial[WIDTH-1:0];
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= S_FIX;
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= raw_a;
                        lo <= {WIDTH{1'b1}};
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] cur_hi = 32'h0;
    logic [31:0] cur_lo = 32'h0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[9];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result from the instruction semantics, using 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin p = sa * sb; return p; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; return p; end
            3'd2: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, cur_lo};
            3'd5: return {cur_hi, a};
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    // Issue one op; lat counts edges after the accepting edge until done is seen.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output bit held);
        held = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            if (hi !== cur_hi || lo !== cur_lo) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic run_check(input string name, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat, bc;
        bit held;
        int exp_lat;
        exp_lat = o[2] ? 0 : 33;
        do_op(o, a, b, lat, bc, held);
        check({name, "_result"}, {hi, lo}, {ehi, elo});
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        check({name, "_hilo_held"}, 64'(held), 64'd1);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    initial begin
        int lat;
        logic [63:0] m;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[7] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        reset_n = 1'b0; start = 1'b0; op = 3'd0; rs_val = 32'h0; rt_val = 32'h0;
        #12;
        check("reset_outputs", {30'h0, busy, done, hi, lo}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

        // Back-to-back MTHI then MTLO on consecutive edges.
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs_val = 32'h12345678;
        @(posedge clk); #1;
        check("mthi_done", {busy, done}, 64'b01);
        check("mthi_hi", {hi, lo}, {32'h12345678, cur_lo});
        op = 3'd5; rs_val = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo_done", {busy, done}, 64'b01);
        check("mtlo_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
        @(posedge clk); #1;
        check("mt_done_clear", {busy, done}, 64'b00);
        cur_hi = 32'h12345678; cur_lo = 32'h9ABCDEF0;

        // Reserved op is ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd6; rs_val = 32'hDEADBEEF; rt_val = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("reserved_ignored", {30'h0, busy, done, hi, lo}, {32'h0, cur_hi, cur_lo} & 64'hFFFFFFFFFFFFFFFF);

        // MTLO pulsed while a DIV is in flight must be ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs_val = 32'h1;
        @(posedge clk); #1;
        start = 1'b0; lat++;
        check("busy_start_hilo_hold", {hi, lo}, {cur_hi, cur_lo});
        while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
        check("busy_start_latency", 64'(lat), 64'd33);
        check("busy_start_result", {hi, lo}, {32'd2, 32'd14});
        cur_hi = 32'd2; cur_lo = 32'd14;

        // Asynchronous reset ten cycles into a DIV.
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'hFFFF0000; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {30'h0, busy, done, hi, lo}, 64'h0);
        cur_hi = 32'h0; cur_lo = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        run_check("after_reset_multu", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            m = model(ro, ra, rb);
            run_check($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, m[63:32], m[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS cores: it executes MULT, MULTU, DIV, DIVU, MTHI and MTLO and owns the architectural HI/LO registers. It is a small sequenced datapath with a 4-state FSM and an iteration counter. It sits beside the main ALU. The control unit issues an operation with `start` and stalls the pipeline or FSM on `busy`. MFHI/MFLO read `hi`/`lo` combinationally.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `rs_val`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `rt_val`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  a multi-cycle operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO were written on the preceding edge.
- `hi`  out  WIDTH  architectural HI.
- `lo`  out  WIDTH  architectural LO.

## Operation
- **FSM states:** IDLE, MUL, DIV, FIX.
- **IDLE, `start` with op MULT/MULTU:**
  - Latch the operand magnitudes: absolute values for signed ops, raw values for unsigned.
  - Latch the result-sign flags.
  - Clear the 6-bit counter and go to MUL.
- **IDLE, `start` with op DIV/DIVU:** same latching, then go to DIV.
- **IDLE, `start` with op MTHI/MTLO:**
  - Write `rs_val` to `hi`/`lo` on that edge.
  - Raise `done` next cycle; `busy` stays low.
- **IDLE, reserved op:** ignored; no `done`, no state change.
- **MUL:** shift-add, one multiplier bit per cycle, into a 64-bit accumulator held separately from `hi`/`lo`. After 32 iterations, go to FIX.
- **DIV:** restoring division, one quotient bit per cycle, into separate remainder/quotient registers. After 32 iterations, go to FIX.
- **FIX:** apply the sign corrections, write `hi`/`lo`, assert `done` next cycle, return to IDLE.
- **Sign rules:**
  - Product is the two's-complement 64-bit negation when operand signs differ.
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
  - Magnitude of 0x80000000 is 2^31, which must be handled in a 32-bit unsigned magnitude.
- **Multiply results:** product[63:32] goes to `hi`, product[31:0] to `lo`.
- **Divide results:** remainder goes to `hi`, quotient to `lo`.
- **Divide by zero (DIV and DIVU):** `lo` = 0xFFFFFFFF, `hi` = `rs_val` as issued; full latency still applies.
- **Signed overflow (0x80000000 / 0xFFFFFFFF):** `lo` = 0x80000000, `hi` = 0.
- **`start` while `busy`:** ignored. The operation in flight and its operands are unaffected.
- **`hi`/`lo` during an operation:** hold their previous values, with no partial updates. An MFHI/MFLO issued before `done` returns the old values.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- **Reset mid-operation:** assertion aborts the operation immediately and asynchronously. All outputs return to reset values; the next `start` after deassertion behaves normally.
- **Mul/div latency:** `start` is accepted on edge E0.
  - `busy`=1 from after E0 through the cycle before E33.
  - Iterations occur on E1..E32; FIX writes `hi`/`lo` on E33.
  - `done`=1 for exactly the cycle after E33, with `busy`=0 in that same cycle.
  - A new `start` may be accepted on E34, i.e. in the `done` cycle.
- **MTHI/MTLO:**
  - Write on E0; `done`=1 in the cycle after E0.
  - Back-to-back MTHI/MTLO on consecutive edges are both accepted.
- **`done` width:** never asserted for more than one consecutive cycle per operation.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` exactly in the cycle after E33; `busy` high for exactly 33 cycles.
- MULT −3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 / 2 -> `lo`=3, `hi`=1.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. DIVU 5 / 0 -> `lo`=0xFFFFFFFF, `hi`=5.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on the next edge -> both registers updated, `done` high two consecutive cycles, `busy` never high. During a DIV, pulse `start` with MTLO 0x1 -> ignored; `hi`/`lo` unchanged until E33.
- Drop `reset_n` 10 cycles into a DIV -> `busy`/`done`/`hi`/`lo` go to 0 without waiting for a clock edge. Then MULTU 6 × 7 -> `lo`=42, `hi`=0 with normal latency.
